// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store initiator for a single-port synchronous-read data memory
// Optional feature macro: LSU_MISALIGN_TRAP_EN (reject misaligned halfword/word accesses).
module lsu_mem_port #(
    parameter bit RESP_ZERO_ON_STORE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [31:0] wbuf;
    logic        req_illegal, req_misalign, req_reject;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt, merged;

    always_comb begin
        req_illegal = 1'b0;
        if (req_we)
            req_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            req_illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    // Low address bits are simply ignored; lane selection uses only the bits that matter.
    assign req_misalign = 1'b0;
`endif

    assign req_reject = req_illegal || req_misalign;

    always_comb begin
        byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'h0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'h0, half_sel};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_reject)
                        state_nxt = RESP;
                    else if (req_we && (req_funct3 == 3'b010))
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 16'h0;
            wbuf       <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata[15:0];
                        wbuf     <= req_wdata;
                        resp_err <= req_reject;
                        if (req_reject)
                            resp_rdata <= 32'h0;
                    end
                end
                CAP: begin
                    if (we_q)
                        wbuf <= merged;
                    else
                        resp_rdata <= load_fmt;
                end
                WR: resp_rdata <= RESP_ZERO_ON_STORE ? 32'h0 : wbuf;
                default: ;
            endcase
        end
    end

    // Memory-side outputs depend only on state and latched registers.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_rw     = (state == WR);
    assign mem_addr   = ((state == RD) || (state == WR)) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = (state == WR) ? wbuf : 32'h0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - scoreboard testbench for lsu_mem_port
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] mem [0:63];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
        int          at;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];

    lsu_mem_port dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_rw)
            mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (rq.size() == 0) begin
                check("unexpected_resp", 32'h1, 32'h0);
            end else begin
                resp_t e;
                e = rq.pop_front();
                check("resp_cycle", cyc, e.at);
                check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                if (e.chk_rdata)
                    check("resp_rdata", resp_rdata, e.rdata);
            end
        end
        if (mem_rw) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'h1, 32'h0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("write_addr", mem_addr, w.addr);
                check("write_data", mem_wdata, w.data);
            end
        end
    end

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat);
        resp_t e;
        int n;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("handshake_timeout", 32'h1, 32'h0);
        end else begin
            e.rdata     = er;
            e.err       = ee;
            e.chk_rdata = !ee;
            e.at        = cyc + lat;
            rq.push_back(e);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            check("drain_timeout", 32'h1, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'h0;
        mem[16] = 32'h8899AABB;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Loads from word 0x40 = 0x8899AABB, issued back to back.
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 3);
        issue(1'b0, 3'b000, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 3);
        issue(1'b0, 3'b100, 32'h43, 32'h0, 32'h00000088, 1'b0, 3);
        issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8899, 1'b0, 3);
        issue(1'b0, 3'b101, 32'h40, 32'h0, 32'h0000AABB, 1'b0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b001, 32'h41, 32'h0, 32'h0, 1'b1, 1);
`else
        issue(1'b0, 3'b001, 32'h41, 32'h0, 32'hFFFFAABB, 1'b0, 3);
`endif
        issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 3);
        drain();

        // Stores: SW, SB, SH read-modify-write, then read back.
        exp_write(32'h40, 32'h11223344);
        issue(1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0, 2);
        exp_write(32'h40, 32'h11EE3344);
        issue(1'b1, 3'b000, 32'h42, 32'h000000EE, 32'h0, 1'b0, 4);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h11EE3344, 1'b0, 3);
        exp_write(32'h40, 32'hCAFE3344);
        issue(1'b1, 3'b001, 32'h42, 32'h1234CAFE, 32'h0, 1'b0, 4);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE3344, 1'b0, 3);
        exp_write(32'h80, 32'hDEADBEEF);
        issue(1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 32'h0, 1'b0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b1, 3'b010, 32'h83, 32'h01020304, 32'h0, 1'b1, 1);
        issue(1'b0, 3'b010, 32'h80, 32'h0, 32'hDEADBEEF, 1'b0, 3);
`else
        exp_write(32'h80, 32'h01020304);
        issue(1'b1, 3'b010, 32'h83, 32'h01020304, 32'h0, 1'b0, 2);
        issue(1'b0, 3'b010, 32'h80, 32'h0, 32'h01020304, 1'b0, 3);
`endif
        drain();

        // Abort an SB with reset during its CAP cycle.
        exp_write(32'h40, 32'hCAFE5544);
        issue(1'b1, 3'b000, 32'h41, 32'h00000055, 32'h0, 1'b0, 4);
        @(posedge clk);
        #2;
        reset = 1'b1;
        rq.delete();
        wq.delete();
        #1;
        check("abort_req_ready", {31'h0, req_ready}, 32'h1);
        check("abort_mem_rw", {31'h0, mem_rw}, 32'h0);
        check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_mem_word", mem[16], 32'hCAFE3344);
        check("abort_ready_after", {31'h0, req_ready}, 32'h1);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE3344, 1'b0, 3);
        drain();

        check("queues_empty", rq.size() + wq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
